// File: rtl/rx_ltssm.sv
// rx_ltssm: RX-side LTSSM slave; qualifies ordered sets, counts and times out.
// RX_LTSSM_TIMEOUT_EN enables the 24 ms / 2 ms state timers.
module rx_ltssm #(
  parameter int DEVICETYPE   = 0,
  parameter int LANESNUMBER  = 16,
  parameter int T24MS_CYCLES = 3000000,
  parameter int T2MS_CYCLES  = 250000
) (
  input  logic                   Pclk,
  input  logic                   Reset,
  input  logic [3:0]             SetRXState,
  output logic                   RXFinishFlag,
  output logic [3:0]             RXExitTo,
  input  logic                   OSValid,
  input  logic [2:0]             OSType,
  input  logic [7:0]             OSLinkNum,
  input  logic [7:0]             OSLaneNum,
  input  logic [LANESNUMBER-1:0] OSLaneMask,
  input  logic [LANESNUMBER-1:0] DetectLanes,
  input  logic [7:0]             ReadLinkNum,
  output logic [7:0]             WriteLinkNum,
  output logic                   WriteLinkNumFlag
);

  typedef enum logic [3:0] {
    DetectQuiet      = 4'h0,
    DetectActive     = 4'h1,
    PollingActive    = 4'h2,
    PollingConfig    = 4'h3,
    CfgLWStart       = 4'h4,
    CfgLWAccept      = 4'h5,
    CfgLaneNumWait   = 4'h6,
    CfgLaneNumActive = 4'h7,
    CfgComplete      = 4'h8,
    CfgIdle          = 4'h9,
    L0               = 4'hA,
    Idle             = 4'hF
  } ltssm_t;

  localparam logic [7:0] Pad = 8'hF7;
  localparam bit IsUp = (DEVICETYPE != 0);

  ltssm_t     State;
  logic [3:0] ConsecCnt;
  logic       Done;
  logic [7:0] prevLink;

  logic       change, lanesOk, match, hit, fire, timeout;
  logic       isTS1, isTS2, isIdle, linkPad, lanePad, linkOk;
  logic       rule, wlFire;
  logic [3:0] need;
  ltssm_t     target;
  logic [4:0] cntInc;
  logic [3:0] cntNxt;
  logic [3:0] exitNxt;
  logic [7:0] wlNxt;

  assign change  = (SetRXState != State);
  assign lanesOk = ((OSLaneMask & DetectLanes) == DetectLanes);
  assign isTS1   = (OSType == 3'd0);
  assign isTS2   = (OSType == 3'd1);
  assign isIdle  = (OSType == 3'd4);
  assign linkPad = (OSLinkNum == Pad);
  assign lanePad = (OSLaneNum == Pad);
  assign linkOk  = (OSLinkNum == ReadLinkNum);

  always_comb begin
    rule   = 1'b0;
    need   = 4'd8;
    target = DetectQuiet;
    unique case (1'b1)
      (State == PollingActive): begin
        rule   = (isTS1 | isTS2) & linkPad & lanePad;
        target = PollingConfig;
      end
      (State == PollingConfig): begin
        rule   = isTS2 & linkPad & lanePad;
        target = CfgLWStart;
      end
      (State == CfgLWStart): begin
        need   = 4'd2;
        target = CfgLWAccept;
        // Upstream adopts whatever link number the partner keeps sending
        if (IsUp)
          rule = isTS1 & ~linkPad &
                 ((ConsecCnt == 4'd0) | (OSLinkNum == prevLink));
        else
          rule = isTS1 & linkOk;
      end
      (State == CfgLWAccept): begin
        need   = 4'd2;
        rule   = isTS1 & linkOk & ~lanePad;
        target = CfgLaneNumWait;
      end
      (State == CfgLaneNumWait): begin
        need   = 4'd2;
        rule   = isTS1 & linkOk & ~lanePad;
        target = CfgLaneNumActive;
      end
      (State == CfgLaneNumActive): begin
        need   = 4'd2;
        rule   = (IsUp ? isTS2 : isTS1) & linkOk & ~lanePad;
        target = CfgComplete;
      end
      (State == CfgComplete): begin
        rule   = isTS2 & linkOk;
        target = CfgIdle;
      end
      (State == CfgIdle): begin
        rule   = isIdle;
        target = L0;
      end
      default: ;
    endcase
  end

  assign match  = OSValid & lanesOk & rule;
  assign cntInc = {1'b0, ConsecCnt} + 5'd1;
  assign hit    = match & (cntInc == {1'b0, need});
  assign fire   = ~change & ~Done & (hit | timeout);
  assign wlFire = fire & hit & IsUp & (State == CfgLWStart);

  always_comb begin
    cntNxt = ConsecCnt;
    if (change)
      cntNxt = 4'd0;
    else if (OSValid)
      cntNxt = match ? ((ConsecCnt == 4'hF) ? 4'hF : cntInc[3:0])
                     : 4'd0;
  end

  always_comb begin
    exitNxt = RXExitTo;
    wlNxt   = WriteLinkNum;
    if (fire)
      exitNxt = hit ? 4'(target) : 4'(DetectQuiet);
    if (wlFire)
      wlNxt = OSLinkNum;
  end

  always_ff @(posedge Pclk) begin
    if (!Reset) begin
      State            <= Idle;
      ConsecCnt        <= 4'd0;
      Done             <= 1'b0;
      prevLink         <= 8'd0;
      RXFinishFlag     <= 1'b0;
      RXExitTo         <= 4'(DetectQuiet);
      WriteLinkNum     <= 8'd0;
      WriteLinkNumFlag <= 1'b0;
    end else begin
      State            <= ltssm_t'(SetRXState);
      ConsecCnt        <= cntNxt;
      Done             <= change ? 1'b0 : (Done | fire);
      prevLink         <= match ? OSLinkNum : prevLink;
      RXFinishFlag     <= fire;
      RXExitTo         <= exitNxt;
      WriteLinkNum     <= wlNxt;
      WriteLinkNumFlag <= wlFire;
    end
  end

`ifdef RX_LTSSM_TIMEOUT_EN
  localparam logic [23:0] Lim24 = 24'(T24MS_CYCLES - 1);
  localparam logic [23:0] Lim2  = 24'(T2MS_CYCLES - 1);

  logic [23:0] Timer;
  logic [23:0] limit;
  logic        timed;

  always_comb begin
    timed = 1'b1;
    limit = Lim2;
    unique case (1'b1)
      (State == PollingActive),
      (State == PollingConfig),
      (State == CfgLWStart):  limit = Lim24;
      (State == CfgLWAccept),
      (State == CfgLaneNumWait),
      (State == CfgLaneNumActive),
      (State == CfgComplete),
      (State == CfgIdle):     limit = Lim2;
      default:                timed = 1'b0;
    endcase
  end

  assign timeout = timed & (Timer == limit);

  always_ff @(posedge Pclk) begin
    if (!Reset)
      Timer <= 24'd0;
    else if (change)
      Timer <= 24'd0;
    else if (timed & ~Done & (Timer != limit))
      Timer <= Timer + 24'd1;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rx_ltssm.sv
// tb_rx_ltssm: directed bench for rx_ltssm, downstream and upstream copies.
// Timeout checks follow RX_LTSSM_TIMEOUT_EN.
module tb_rx_ltssm;

  logic        Pclk = 1'b0;
  logic        Reset;
  logic [3:0]  SetRXState;
  logic        OSValid;
  logic [2:0]  OSType;
  logic [7:0]  OSLinkNum;
  logic [7:0]  OSLaneNum;
  logic [15:0] OSLaneMask;
  logic [15:0] DetectLanes;
  logic [7:0]  ReadLinkNum;

  logic        dnFlag, upFlag;
  logic [3:0]  dnExit, upExit;
  logic [7:0]  dnWl, upWl;
  logic        dnWlFlag, upWlFlag;

  int vectors = 0;
  int miscompares = 0;
  int seenDn, seenUp, firstCyc;

  localparam logic [2:0] TS1 = 3'd0;
  localparam logic [2:0] TS2 = 3'd1;
  localparam logic [2:0] IDL = 3'd4;
  localparam logic [7:0] PAD = 8'hF7;

  always #5 Pclk = ~Pclk;

  rx_ltssm #(.DEVICETYPE(0), .LANESNUMBER(16), .T2MS_CYCLES(100)) dn (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(dnFlag), .RXExitTo(dnExit),
    .OSValid(OSValid), .OSType(OSType),
    .OSLinkNum(OSLinkNum), .OSLaneNum(OSLaneNum),
    .OSLaneMask(OSLaneMask), .DetectLanes(DetectLanes),
    .ReadLinkNum(ReadLinkNum), .WriteLinkNum(dnWl),
    .WriteLinkNumFlag(dnWlFlag)
  );

  rx_ltssm #(.DEVICETYPE(1), .LANESNUMBER(16), .T2MS_CYCLES(100)) up (
    .Pclk(Pclk), .Reset(Reset), .SetRXState(SetRXState),
    .RXFinishFlag(upFlag), .RXExitTo(upExit),
    .OSValid(OSValid), .OSType(OSType),
    .OSLinkNum(OSLinkNum), .OSLaneNum(OSLaneNum),
    .OSLaneMask(OSLaneMask), .DetectLanes(DetectLanes),
    .ReadLinkNum(ReadLinkNum), .WriteLinkNum(upWl),
    .WriteLinkNumFlag(upWlFlag)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic sendOS(input logic [2:0] t, input logic [7:0] lk,
                        input logic [7:0] ln);
    OSValid   = 1'b1;
    OSType    = t;
    OSLinkNum = lk;
    OSLaneNum = ln;
    step();
    OSValid   = 1'b0;
    seenDn |= int'(dnFlag);
    seenUp |= int'(upFlag);
  endtask

  task automatic enter(input logic [3:0] s);
    SetRXState = s;
    step();
    step();
    seenDn = 0;
    seenUp = 0;
  endtask

  initial begin
    Reset       = 1'b0;
    SetRXState  = 4'hF;
    OSValid     = 1'b0;
    OSType      = 3'd7;
    OSLinkNum   = PAD;
    OSLaneNum   = PAD;
    OSLaneMask  = 16'hFFFF;
    DetectLanes = 16'hFFFF;
    ReadLinkNum = 8'h01;
    seenDn = 0;
    seenUp = 0;
    firstCyc = 0;

    step();
    step();
    chk("rst_flag", {31'd0, dnFlag}, 32'd0);
    chk("rst_exit", {28'd0, dnExit}, 32'd0);
    chk("rst_wlflag", {31'd0, upWlFlag}, 32'd0);
    chk("rst_wl", {24'd0, upWl}, 32'd0);
    chk("rst_state", {28'd0, dn.State}, 32'hF);
    Reset = 1'b1;

    // PollingActive: flag on the 8th set only, then silence
    enter(4'd2);
    for (int i = 0; i < 7; i++) sendOS(TS1, PAD, PAD);
    chk("pa_early", seenDn + seenUp, 32'd0);
    sendOS(TS1, PAD, PAD);
    chk("pa_flag", {31'd0, dnFlag}, 32'd1);
    chk("pa_exit", {28'd0, dnExit}, 32'd3);
    chk("pa_exit_up", {28'd0, upExit}, 32'd3);
    step();
    chk("pa_pulse", {31'd0, dnFlag}, 32'd0);
    seenDn = 0;
    for (int i = 0; i < 8; i++) sendOS(TS1, PAD, PAD);
    chk("pa_done", seenDn, 32'd0);

    // PollingConfig: interrupted run restarts the count
    enter(4'd3);
    for (int i = 0; i < 5; i++) sendOS(TS2, PAD, PAD);
    sendOS(TS1, PAD, PAD);
    for (int i = 0; i < 7; i++) sendOS(TS2, PAD, PAD);
    chk("pc_early", seenDn, 32'd0);
    sendOS(TS2, PAD, PAD);
    chk("pc_flag", {31'd0, dnFlag}, 32'd1);
    chk("pc_exit", {28'd0, dnExit}, 32'd4);

    // Missing detected lane never matches
    enter(4'd2);
    OSLaneMask = 16'h7FFF;
    for (int i = 0; i < 8; i++) sendOS(TS1, PAD, PAD);
    chk("mask_none", seenDn, 32'd0);
    OSLaneMask = 16'hFFFF;
    for (int i = 0; i < 8; i++) sendOS(TS1, PAD, PAD);
    chk("mask_ok", seenDn, 32'd1);

    // CfgLWStart: link 01 accepted by both ports
    enter(4'd4);
    sendOS(TS1, 8'h01, PAD);
    sendOS(TS1, 8'h01, PAD);
    chk("lw_up_flag", {31'd0, upFlag}, 32'd1);
    chk("lw_up_exit", {28'd0, upExit}, 32'd5);
    chk("lw_up_wlf", {31'd0, upWlFlag}, 32'd1);
    chk("lw_up_wl", {24'd0, upWl}, 32'h01);
    chk("lw_dn_flag", {31'd0, dnFlag}, 32'd1);
    chk("lw_dn_wlf", {31'd0, dnWlFlag}, 32'd0);
    step();
    chk("lw_wlf_pulse", {31'd0, upWlFlag}, 32'd0);

    // Upstream needs two equal consecutive links; downstream rejects 02/03
    enter(4'd2);
    enter(4'd4);
    sendOS(TS1, 8'h02, PAD);
    sendOS(TS1, 8'h03, PAD);
    sendOS(TS1, 8'h03, PAD);
    chk("lw_chg_early", seenUp, 32'd0);
    sendOS(TS1, 8'h03, PAD);
    chk("lw_chg_flag", {31'd0, upFlag}, 32'd1);
    chk("lw_chg_wl", {24'd0, upWl}, 32'h03);
    chk("lw_chg_dn", seenDn, 32'd0);

    // CfgLaneNumActive: upstream wants TS2, downstream TS1
    enter(4'd7);
    sendOS(TS2, 8'h01, 8'h00);
    sendOS(TS2, 8'h01, 8'h00);
    chk("lna_up", {31'd0, upFlag}, 32'd1);
    chk("lna_up_exit", {28'd0, upExit}, 32'd8);
    chk("lna_dn_none", seenDn, 32'd0);
    enter(4'd6);
    enter(4'd7);
    sendOS(TS1, 8'h01, 8'h00);
    sendOS(TS1, 8'h01, 8'h00);
    chk("lna_dn", {31'd0, dnFlag}, 32'd1);
    chk("lna_up_none", seenUp, 32'd0);

    // CfgComplete with no ordered sets
    SetRXState = 4'd8;
    step();
    for (int k = 1; k <= 150; k++) begin
      step();
      if (dnFlag && firstCyc == 0) firstCyc = k;
    end
`ifdef RX_LTSSM_TIMEOUT_EN
    chk("to_cycle", firstCyc, 32'd100);
    chk("to_exit", {28'd0, dnExit}, 32'd0);
`else
    chk("to_none", firstCyc, 32'd0);
`endif

    // Reset mid-count in CfgIdle
    enter(4'd9);
    for (int i = 0; i < 5; i++) sendOS(IDL, PAD, PAD);
    Reset = 1'b0;
    step();
    chk("mid_state", {28'd0, dn.State}, 32'hF);
    chk("mid_cnt", {28'd0, dn.ConsecCnt}, 32'd0);
    Reset = 1'b1;
    step();
    step();
    seenDn = 0;
    for (int i = 0; i < 7; i++) sendOS(IDL, PAD, PAD);
    chk("ci_early", seenDn, 32'd0);
    sendOS(IDL, PAD, PAD);
    chk("ci_flag", {31'd0, dnFlag}, 32'd1);
    chk("ci_exit", {28'd0, dnExit}, 32'hA);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
